// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared types and constants for the counter 7-segment display
//
// Purpose : conversion FSM state encoding, digit-index width/values,
//           datapath widths and the active-low segment patterns {g,f,e,d,c,b,a}.
// Ports   : none (package).
package seg_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  localparam int CNT_W     = 7;
  localparam int BCD_W     = 12;
  localparam int WORK_W    = BCD_W + CNT_W;  // {bcd_work, bin}
  localparam int SHIFTS    = CNT_W;

  localparam int DIG_IDX_W = 2;
  localparam logic [DIG_IDX_W-1:0] DIG_ONES     = 2'd0;
  localparam logic [DIG_IDX_W-1:0] DIG_TENS     = 2'd1;
  localparam logic [DIG_IDX_W-1:0] DIG_HUNDREDS = 2'd2;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD digit to active-low 7-segment decoder
//
// Purpose : maps one BCD nibble to its segment pattern; codes 10-15 go blank.
// Ports   : i_bcd [3:0]  BCD digit
//           o_seg [6:0]  segments {g,f,e,d,c,b,a}, active-low
module bcd_to_seg
  import seg_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cnt_seg_display.sv
// rtl/cnt_seg_display.sv - counter snapshot to BCD and 3-digit multiplexed 7-segment driver
//
// Purpose : samples a 7-bit count, converts it to three BCD digits with a
//           one-bit-per-cycle shift-add-3 engine (9-cycle loop), and scans the
//           latched digits onto a common-anode display.
// Config  : define LEADING_ZERO_BLANK_EN to blank leading-zero hundreds/tens.
// Params  : SCAN_DIV  clock cycles per digit slot (>= 1)
// Ports   : i_clk        system clock
//           i_rst        synchronous reset, active-high
//           i_cnt_in     [6:0]  binary count 0..127
//           o_bcd        [11:0] latched {hundreds, tens, ones}
//           o_bcd_valid  one-cycle pulse when o_bcd updates
//           o_an         [2:0]  digit enables, active-low one-hot, [0] = ones
//           o_seg        [6:0]  segments {g,f,e,d,c,b,a}, active-low
module cnt_seg_display
  import seg_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CNT_W-1:0] i_cnt_in,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_bcd_valid,
  output logic [2:0]       o_an,
  output logic [6:0]       o_seg
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  // ---------------- conversion engine ----------------
  conv_state_t       r_state;
  conv_state_t       w_next_state;
  logic [WORK_W-1:0] r_work;
  logic [WORK_W-1:0] w_work_adj;
  logic [2:0]        r_bit_cnt;
  logic              w_load;
  logic              w_shift;
  logic              w_done;
  logic [BCD_W-1:0]  r_bcd;
  logic              r_bcd_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  w_next_state = ST_SHIFT;
      ST_SHIFT: if (r_bit_cnt == 3'(SHIFTS - 1)) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load  = (r_state == ST_IDLE);
    w_shift = (r_state == ST_SHIFT);
    w_done  = (r_state == ST_DONE);
  end

  // Add-3 on every BCD nibble that is >= 5 before it is doubled by the shift.
  // The hundreds nibble never reaches 5 for a 7-bit input but is kept uniform.
  always_comb begin
    w_work_adj = r_work;
    for (int i = 0; i < 3; i++) begin
      if (r_work[CNT_W + 4*i +: 4] >= 4'd5)
        w_work_adj[CNT_W + 4*i +: 4] = r_work[CNT_W + 4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_work      <= '0;
      r_bit_cnt   <= '0;
      r_bcd       <= '0;
      r_bcd_valid <= 1'b0;
    end else begin
      r_bcd_valid <= 1'b0;
      if (w_load) begin
        r_work    <= {{BCD_W{1'b0}}, i_cnt_in};
        r_bit_cnt <= '0;
      end
      if (w_shift) begin
        r_work    <= w_work_adj << 1;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_done) begin
        r_bcd       <= r_work[WORK_W-1:CNT_W];
        r_bcd_valid <= 1'b1;
      end
    end
  end

  assign o_bcd       = r_bcd;
  assign o_bcd_valid = r_bcd_valid;

  // ---------------- display scan ----------------
  logic [SCAN_W-1:0]    r_scan_cnt;
  logic                 w_tick;
  logic [DIG_IDX_W-1:0] r_dig_idx;
  logic [3:0]           w_digit;
  logic [2:0]           w_an_sel;
  logic [6:0]           w_seg_dec;
  logic [6:0]           w_seg_sel;
  logic [2:0]           r_an;
  logic [6:0]           r_seg;

  assign w_tick = (r_scan_cnt == SCAN_LAST);

  always_comb begin
    w_digit  = r_bcd[3:0];
    w_an_sel = 3'b110;
    case (r_dig_idx)
      DIG_TENS: begin
        w_digit  = r_bcd[7:4];
        w_an_sel = 3'b101;
      end
      DIG_HUNDREDS: begin
        w_digit  = r_bcd[11:8];
        w_an_sel = 3'b011;
      end
      default: ;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  always_comb begin
    w_seg_sel = w_seg_dec;
`ifdef LEADING_ZERO_BLANK_EN
    if (r_dig_idx == DIG_HUNDREDS && r_bcd[11:8] == 4'd0)
      w_seg_sel = SEG_BLANK;
    if (r_dig_idx == DIG_TENS && r_bcd[11:4] == 8'd0)
      w_seg_sel = SEG_BLANK;
`endif
  end

  // The tick displays the digit dig_idx currently points at, then advances it,
  // so the first slot after reset is the ones digit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scan_cnt <= '0;
      r_dig_idx  <= DIG_ONES;
      r_an       <= 3'b111;
      r_seg      <= SEG_BLANK;
    end else begin
      r_scan_cnt <= w_tick ? '0 : r_scan_cnt + SCAN_W'(1);
      if (w_tick) begin
        r_an      <= w_an_sel;
        r_seg     <= w_seg_sel;
        r_dig_idx <= (r_dig_idx == DIG_HUNDREDS) ? DIG_ONES
                                                 : r_dig_idx + DIG_IDX_W'(1);
      end
    end
  end

  assign o_an  = r_an;
  assign o_seg = r_seg;

endmodule
